// File: rtl/pulpemu_rst_pkg.sv
// rtl/pulpemu_rst_pkg.sv - shared types and helpers for the reset/clock-enable sequencer
//
// Purpose : sequencer state and reset-cause encodings, plus a parameter
//           clamp so that zero-length delays behave as one cycle.
// Ports   : none (package).
package pulpemu_rst_pkg;

   typedef enum logic [2:0] {
      WAIT_LOCK  = 3'd0,
      CLK_STABLE = 3'd1,
      SOC_REL    = 3'd2,
      CL_REL     = 3'd3,
      RUN        = 3'd4,
      HOLD       = 3'd5
   } rst_state_e;

   typedef enum logic [1:0] {
      CAUSE_POR  = 2'b00,
      CAUSE_LOCK = 2'b01,
      CAUSE_EXT  = 2'b10,
      CAUSE_WDT  = 2'b11
   } rst_cause_e;

   function automatic int unsigned at_least_one(input int unsigned v);
      return (v == 32'd0) ? 32'd1 : v;
   endfunction

endpackage

// File: rtl/pulpemu_rst_debounce.sv
// rtl/pulpemu_rst_debounce.sv - synchroniser and debouncer for the external reset button
//
// Purpose : 2-flop synchronises the bouncy button, then flips a debounced
//           level once the synchronised input has differed from it for
//           DEBOUNCE_CYCLES consecutive cycles.
// Ports   : clk_i   - clock
//           rstn_i  - asynchronous active-low reset
//           btn_i   - raw button, active high, asynchronous
//           level_o - debounced button level (registered)
//           press_o - one-cycle pulse on each 0->1 flip of level_o
module pulpemu_rst_debounce
   import pulpemu_rst_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1024
) (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic btn_i,
   output logic level_o,
   output logic press_o
);

   localparam int unsigned DB_N = at_least_one(DEBOUNCE_CYCLES);
   localparam int unsigned DB_W = (DB_N > 32'd1) ? $clog2(DB_N) : 32'd1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_N - 32'd1);

   logic [1:0]      sync_q;
   logic            btn_s;
   logic [DB_W-1:0] cnt_q;
   logic            level_q;
   logic            press_q;

   assign btn_s   = sync_q[1];
   assign level_o = level_q;
   assign press_o = press_q;

   // The counter only runs while the input disagrees with the level and is
   // cleared at the flip, so it never passes DB_LAST and cannot wrap.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         sync_q  <= 2'b00;
         cnt_q   <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], btn_i};
         press_q <= 1'b0;
         if (btn_s != level_q) begin
            if (cnt_q == DB_LAST) begin
               level_q <= btn_s;
               press_q <= btn_s;
               cnt_q   <= '0;
            end else begin
               cnt_q <= cnt_q + DB_W'(1);
            end
         end else begin
            cnt_q <= '0;
         end
      end
   end

endmodule

// File: rtl/pulpemu_rst_seq.sv
// rtl/pulpemu_rst_seq.sv - reset/clock-enable sequencer for the FPGA emulation top
//
// Purpose : waits for clock lock, then enables chip clocks, releases the SoC
//           reset and the cluster reset in order; re-sequences on lock loss
//           or a debounced button press. Optional watchdog behind macro
//           PULPEMU_RST_WDT_EN (adds WDT_CYCLES and wdt_kick_i).
// Ports   : clk_i          - free-running clock
//           rstn_i         - asynchronous active-low reset
//           mmcm_locked_i  - clock generator lock (asynchronous)
//           ext_rst_i      - reset button, active high (asynchronous, bouncy)
//           bootmode_i     - boot mode pin (asynchronous)
//           wdt_kick_i     - watchdog kick (only with PULPEMU_RST_WDT_EN)
//           clk_en_o       - chip clock gate enable
//           soc_rstn_o     - SoC reset, active low
//           cluster_rstn_o - cluster reset, active low
//           bootmode_o     - boot mode latched when clocks are enabled
//           rst_cause_o    - last reset cause (00 POR, 01 LOCK, 10 EXT, 11 WDT)
//           busy_o         - high whenever the sequencer is not in RUN
module pulpemu_rst_seq
   import pulpemu_rst_pkg::*;
#(
   parameter int unsigned LOCK_WAIT_CYCLES = 16,
   parameter int unsigned SOC_DELAY        = 64,
   parameter int unsigned CLUSTER_DELAY    = 32,
   parameter int unsigned HOLD_CYCLES      = 8,
   parameter int unsigned DEBOUNCE_CYCLES  = 1024,
   parameter int unsigned CNT_W            = 16
`ifdef PULPEMU_RST_WDT_EN
   ,
   parameter int unsigned WDT_CYCLES       = 32'd1 << 20
`endif
) (
   input  logic       clk_i,
   input  logic       rstn_i,
   input  logic       mmcm_locked_i,
   input  logic       ext_rst_i,
   input  logic       bootmode_i,
`ifdef PULPEMU_RST_WDT_EN
   input  logic       wdt_kick_i,
`endif
   output logic       clk_en_o,
   output logic       soc_rstn_o,
   output logic       cluster_rstn_o,
   output logic       bootmode_o,
   output logic [1:0] rst_cause_o,
   output logic       busy_o
);

   localparam logic [CNT_W-1:0] LW_LAST   = CNT_W'(at_least_one(LOCK_WAIT_CYCLES) - 32'd1);
   localparam logic [CNT_W-1:0] SOC_LAST  = CNT_W'(at_least_one(SOC_DELAY) - 32'd1);
   localparam logic [CNT_W-1:0] CL_LAST   = CNT_W'(at_least_one(CLUSTER_DELAY) - 32'd1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(at_least_one(HOLD_CYCLES) - 32'd1);

   logic [1:0] lock_sync_q, boot_sync_q;
   logic       lock_s, boot_s;
   logic       btn_level, btn_press;

   rst_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             clk_en_q, clk_en_d;
   logic             soc_q, soc_d;
   logic             cl_q, cl_d;
   logic             boot_q, boot_d;
   rst_cause_e       cause_q, cause_d;
   logic             busy_q, busy_d;
   logic             wdt_expire;
   logic             lock_lost, press_ok;

   assign lock_s = lock_sync_q[1];
   assign boot_s = boot_sync_q[1];

   pulpemu_rst_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .btn_i  (ext_rst_i),
      .level_o(btn_level),
      .press_o(btn_press)
   );

`ifdef PULPEMU_RST_WDT_EN
   localparam int unsigned WDT_N = at_least_one(WDT_CYCLES);
   localparam int unsigned WDT_W = (WDT_N > 32'd1) ? $clog2(WDT_N) : 32'd1;
   localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_N - 32'd1);

   logic [WDT_W-1:0] wdt_cnt_q;

   // A kick in the same cycle as the terminal count still rescues the run.
   assign wdt_expire = (state_q == RUN) && !wdt_kick_i && (wdt_cnt_q == WDT_LAST);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wdt_cnt_q <= '0;
      end else if ((state_q != RUN) || wdt_kick_i) begin
         wdt_cnt_q <= '0;
      end else if (wdt_cnt_q != WDT_LAST) begin
         wdt_cnt_q <= wdt_cnt_q + WDT_W'(1);
      end
   end
`else
   assign wdt_expire = 1'b0;
`endif

   // Lock loss in CLK_STABLE is not a re-sequence (clocks never ran); it
   // simply falls back to WAIT_LOCK inside the case below.
   assign lock_lost = !lock_s && (state_q inside {SOC_REL, CL_REL, RUN});
   assign press_ok  = btn_press && lock_s &&
                      (state_q inside {CLK_STABLE, SOC_REL, CL_REL, RUN});

   always_comb begin
      state_d  = state_q;
      cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
      clk_en_d = clk_en_q;
      soc_d    = soc_q;
      cl_d     = cl_q;
      boot_d   = boot_q;
      cause_d  = cause_q;
      busy_d   = busy_q;

      case (state_q)
         WAIT_LOCK: begin
            cnt_d    = '0;
            clk_en_d = 1'b0;
            soc_d    = 1'b0;
            cl_d     = 1'b0;
            boot_d   = 1'b0;
            busy_d   = 1'b1;
            if (lock_s) state_d = CLK_STABLE;
         end
         CLK_STABLE: begin
            if (!lock_s) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == LW_LAST) begin
               clk_en_d = 1'b1;
               boot_d   = boot_s;
               state_d  = SOC_REL;
               cnt_d    = '0;
            end
         end
         SOC_REL: begin
            if (cnt_q == SOC_LAST) begin
               soc_d   = 1'b1;
               state_d = CL_REL;
               cnt_d   = '0;
            end
         end
         CL_REL: begin
            if (cnt_q == CL_LAST) begin
               cl_d    = 1'b1;
               busy_d  = 1'b0;
               state_d = RUN;
               cnt_d   = '0;
            end
         end
         RUN: begin
            cnt_d = '0;
         end
         HOLD: begin
            soc_d  = 1'b0;
            cl_d   = 1'b0;
            busy_d = 1'b1;
            // Once expired the counter parks at HOLD_LAST while the button
            // is still held, keeping clocks off until release.
            if (cnt_q == HOLD_LAST) begin
               cnt_d    = cnt_q;
               clk_en_d = 1'b0;
               if (!btn_level) begin
                  state_d = WAIT_LOCK;
                  cnt_d   = '0;
               end
            end
         end
         default: begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
         end
      endcase

      if (lock_lost || press_ok || wdt_expire) begin
         state_d  = HOLD;
         cnt_d    = '0;
         soc_d    = 1'b0;
         cl_d     = 1'b0;
         busy_d   = 1'b1;
         boot_d   = boot_q;
         clk_en_d = clk_en_q;
         if (lock_lost) begin
            cause_d  = CAUSE_LOCK;
            clk_en_d = 1'b0;
         end else if (press_ok) begin
            cause_d = CAUSE_EXT;
         end else begin
            cause_d = CAUSE_WDT;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         lock_sync_q <= 2'b00;
         boot_sync_q <= 2'b00;
         state_q     <= WAIT_LOCK;
         cnt_q       <= '0;
         clk_en_q    <= 1'b0;
         soc_q       <= 1'b0;
         cl_q        <= 1'b0;
         boot_q      <= 1'b0;
         cause_q     <= CAUSE_POR;
         busy_q      <= 1'b1;
      end else begin
         lock_sync_q <= {lock_sync_q[0], mmcm_locked_i};
         boot_sync_q <= {boot_sync_q[0], bootmode_i};
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         clk_en_q    <= clk_en_d;
         soc_q       <= soc_d;
         cl_q        <= cl_d;
         boot_q      <= boot_d;
         cause_q     <= cause_d;
         busy_q      <= busy_d;
      end
   end

   assign clk_en_o       = clk_en_q;
   assign soc_rstn_o     = soc_q;
   assign cluster_rstn_o = cl_q;
   assign bootmode_o     = boot_q;
   assign rst_cause_o    = cause_q;
   assign busy_o         = busy_q;

endmodule

// File: tb/tb_pulpemu_rst_seq.sv
// tb/tb_pulpemu_rst_seq.sv - self-checking bench for pulpemu_rst_seq
module tb_pulpemu_rst_seq;

   localparam int LW = 4;
   localparam int SD = 8;
   localparam int CD = 4;
   localparam int HC = 3;
   localparam int DB = 5;
`ifdef PULPEMU_RST_WDT_EN
   localparam int WDT = 16;
   logic kick = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rstn = 1'b1;
   logic       lock = 1'b0;
   logic       ext = 1'b0;
   logic       boot = 1'b0;
   logic       clk_en, soc_rstn, cl_rstn, boot_o, busy;
   logic [1:0] cause;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pulpemu_rst_seq #(
      .LOCK_WAIT_CYCLES(LW),
      .SOC_DELAY(SD),
      .CLUSTER_DELAY(CD),
      .HOLD_CYCLES(HC),
      .DEBOUNCE_CYCLES(DB),
      .CNT_W(16)
`ifdef PULPEMU_RST_WDT_EN
      ,
      .WDT_CYCLES(WDT)
`endif
   ) dut (
      .clk_i         (clk),
      .rstn_i        (rstn),
      .mmcm_locked_i (lock),
      .ext_rst_i     (ext),
      .bootmode_i    (boot),
`ifdef PULPEMU_RST_WDT_EN
      .wdt_kick_i    (kick),
`endif
      .clk_en_o      (clk_en),
      .soc_rstn_o    (soc_rstn),
      .cluster_rstn_o(cl_rstn),
      .bootmode_o    (boot_o),
      .rst_cause_o   (cause),
      .busy_o        (busy)
   );

   // Advance n active edges; afterwards cyc is the number of the last edge
   // and inputs assigned now are sampled at edge cyc+1.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic sel(input int w);
      case (w)
         0:       return clk_en;
         1:       return soc_rstn;
         2:       return cl_rstn;
         default: return busy;
      endcase
   endfunction

   // Returns the edge at which the selected output took value val, or -1.
   task automatic wait_sig(input int w, input logic val, input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         if (sel(w) === val) begin
            at = cyc;
            return;
         end
         step(1);
      end
   endtask

   // Fresh power-up; lock rises so that it is first sampled at edge lock_edge.
   task automatic power_up(input logic bm, output int lock_edge);
      rstn = 1'b0;
      lock = 1'b0;
      ext  = 1'b0;
      boot = bm;
`ifdef PULPEMU_RST_WDT_EN
      kick = 1'b0;
`endif
      step(2);
      rstn = 1'b1;
      step($urandom_range(1, 6));
      lock = 1'b1;
      lock_edge = cyc + 1;
   endtask

   task automatic test_reset();
      #2 rstn = 1'b0;
      step(2);
      checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL reset_clk_en: got %b expected 0", clk_en); end
      checks++; if (soc_rstn !== 1'b0) begin errors++; $display("FAIL reset_soc_rstn: got %b expected 0", soc_rstn); end
      checks++; if (cl_rstn !== 1'b0) begin errors++; $display("FAIL reset_cluster_rstn: got %b expected 0", cl_rstn); end
      checks++; if (boot_o !== 1'b0) begin errors++; $display("FAIL reset_bootmode: got %b expected 0", boot_o); end
      checks++; if (cause !== 2'b00) begin errors++; $display("FAIL reset_cause: got %b expected 00", cause); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", busy); end
      rstn = 1'b1;
      step(12);
      checks++;
      if ({clk_en, soc_rstn, cl_rstn, busy} !== 4'b0001) begin
         errors++; $display("FAIL wait_lock_idle: got %b expected 0001", {clk_en, soc_rstn, cl_rstn, busy});
      end
   endtask

   task automatic test_power_up();
      for (int it = 0; it < 3; it++) begin
         logic bm;
         int   l, a, bad, en_exp;
         bm = 1'($urandom_range(0, 1));
         power_up(bm, l);
         en_exp = l + 2 + LW;
         wait_sig(0, 1'b1, 200, a);
         checks++; if (a != en_exp) begin errors++; $display("FAIL clk_en_rise: got edge %0d expected %0d", a, en_exp); end
         wait_sig(1, 1'b1, 200, a);
         checks++; if (a != en_exp + SD) begin errors++; $display("FAIL soc_release: got edge %0d expected %0d", a, en_exp + SD); end
         wait_sig(2, 1'b1, 200, a);
         checks++; if (a != en_exp + SD + CD) begin errors++; $display("FAIL cluster_release: got edge %0d expected %0d", a, en_exp + SD + CD); end
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_in_run: got %b expected 0", busy); end
         checks++; if (cause !== 2'b00) begin errors++; $display("FAIL por_cause: got %b expected 00", cause); end
         checks++; if (boot_o !== bm) begin errors++; $display("FAIL bootmode_latch: got %b expected %b", boot_o, bm); end
         bad = 0;
         for (int i = 0; i < 20; i++) begin
            boot = 1'($urandom_range(0, 1));
            step(1);
            if (boot_o !== bm) bad++;
         end
         checks++; if (bad != 0) begin errors++; $display("FAIL bootmode_stable: got %0d changes expected 0", bad); end
      end
   endtask

   task automatic test_lock_glitch();
      for (int it = 0; it < 2; it++) begin
         int l, h, a, r, seen;
         power_up(1'b0, l);
         h = $urandom_range(1, LW);
         step(h);
         lock = 1'b0;
         seen = 0;
         for (int i = 0; i < 20; i++) begin
            step(1);
            if (clk_en !== 1'b0) seen++;
         end
         checks++; if (seen != 0) begin errors++; $display("FAIL glitch_no_clk_en: got %0d high cycles expected 0", seen); end
         lock = 1'b1;
         r = cyc + 1;
         wait_sig(0, 1'b1, 200, a);
         checks++; if (a != r + 2 + LW) begin errors++; $display("FAIL relock_clk_en: got edge %0d expected %0d", a, r + 2 + LW); end
         wait_sig(3, 1'b0, 200, a);
         checks++; if (a != r + 2 + LW + SD + CD) begin errors++; $display("FAIL relock_run: got edge %0d expected %0d", a, r + 2 + LW + SD + CD); end
         checks++; if (cause !== 2'b00) begin errors++; $display("FAIL glitch_cause: got %b expected 00", cause); end
      end
   endtask

   task automatic test_button_bounce();
      for (int it = 0; it < 2; it++) begin
         logic bm, prev_soc, prev_en, en_at_fall;
         logic [1:0] cause_at_fall;
         int l, a, t0, b, hl, falls, fall_edge, en_fall, rise;
         bm = 1'($urandom_range(0, 1));
         power_up(bm, l);
         wait_sig(3, 1'b0, 200, a);
         hl = $urandom_range(6, 14);
         t0 = cyc;
         b = t0 + 1 + 20;
         falls = 0; fall_edge = -1; en_fall = -1; rise = -1;
         en_at_fall = 1'b0; cause_at_fall = 2'b00;
         for (int i = 0; i < 150; i++) begin
            if (i < 20) ext = ((i / 2) % 2 == 0);
            else if (i < 20 + hl) ext = 1'b1;
            else ext = 1'b0;
            if (i == 20 + hl) boot = ~bm;
            prev_soc = soc_rstn;
            prev_en = clk_en;
            step(1);
            if (prev_soc && !soc_rstn) begin
               falls++; fall_edge = cyc; en_at_fall = clk_en; cause_at_fall = cause;
            end
            if (prev_en && !clk_en) en_fall = cyc;
            if (!prev_en && clk_en) begin
               rise = cyc;
               break;
            end
         end
         checks++; if (falls != 1) begin errors++; $display("FAIL press_count: got %0d hold entries expected 1", falls); end
         checks++; if (fall_edge != b + DB + 2) begin errors++; $display("FAIL press_hold_entry: got edge %0d expected %0d", fall_edge, b + DB + 2); end
         checks++; if (cause_at_fall !== 2'b10) begin errors++; $display("FAIL press_cause: got %b expected 10", cause_at_fall); end
         checks++; if (en_at_fall !== 1'b1) begin errors++; $display("FAIL press_keeps_clk: got %b expected 1", en_at_fall); end
         checks++; if (en_fall != fall_edge + HC) begin errors++; $display("FAIL hold_clk_off: got edge %0d expected %0d", en_fall, fall_edge + HC); end
         checks++; if (rise != b + hl + DB + 3 + LW) begin errors++; $display("FAIL press_resequence: got edge %0d expected %0d", rise, b + hl + DB + 3 + LW); end
         checks++; if (boot_o !== ~bm) begin errors++; $display("FAIL bootmode_relatch: got %b expected %b", boot_o, ~bm); end
      end
   endtask

   task automatic test_simultaneous();
      int l, a, b;
      power_up(1'b0, l);
      wait_sig(3, 1'b0, 200, a);
      step($urandom_range(0, 5));
      ext = 1'b1;
      b = cyc + 1;
      step(5);
      lock = 1'b0;
      step(2);
      checks++; if ({clk_en, soc_rstn} !== 2'b11) begin errors++; $display("FAIL simul_before: got %b expected 11", {clk_en, soc_rstn}); end
      step(1);
      checks++; if (cyc != b + DB + 2) begin errors++; $display("FAIL simul_edge: got edge %0d expected %0d", cyc, b + DB + 2); end
      checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL simul_clk_en: got %b expected 0", clk_en); end
      checks++; if (cause !== 2'b01) begin errors++; $display("FAIL simul_cause: got %b expected 01", cause); end
      checks++; if ({soc_rstn, cl_rstn, busy} !== 3'b001) begin errors++; $display("FAIL simul_resets: got %b expected 001", {soc_rstn, cl_rstn, busy}); end
      ext = 1'b0;
      lock = 1'b1;
      wait_sig(3, 1'b0, 300, a);
      checks++; if (a < 0) begin errors++; $display("FAIL simul_recover: got %0d expected return to run", a); end
      checks++; if (cause !== 2'b01) begin errors++; $display("FAIL cause_sticky: got %b expected 01", cause); end
   endtask

   task automatic test_async_reset();
      int l, a, k;
      power_up(1'b1, l);
      wait_sig(3, 1'b0, 200, a);
      lock = 1'b0;
      step(3);
      checks++; if (cause !== 2'b01) begin errors++; $display("FAIL lockloss_cause: got %b expected 01", cause); end
      #2 rstn = 1'b0;
      lock = 1'b1;
      #1;
      checks++;
      if ({clk_en, soc_rstn, cl_rstn, boot_o, cause, busy} !== 7'b0000001) begin
         errors++; $display("FAIL async_reset: got %b expected 0000001", {clk_en, soc_rstn, cl_rstn, boot_o, cause, busy});
      end
      @(posedge clk);
      #1;
      rstn = 1'b1;
      k = cyc;
      wait_sig(0, 1'b1, 200, a);
      checks++; if (a != k + 3 + LW) begin errors++; $display("FAIL post_reset_clk_en: got edge %0d expected %0d", a, k + 3 + LW); end
   endtask

`ifdef PULPEMU_RST_WDT_EN
   task automatic test_wdt();
      int l, a, bad, k;
      power_up(1'b0, l);
      wait_sig(3, 1'b0, 200, a);
      bad = 0;
      for (int n = 0; n < 6; n++) begin
         for (int j = 0; j < 9; j++) begin
            step(1);
            if (busy !== 1'b0) bad++;
         end
         kick = 1'b1;
         step(1);
         kick = 1'b0;
         if (busy !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL wdt_kicked: got %0d busy cycles expected 0", bad); end
      k = cyc;
      wait_sig(1, 1'b0, 100, a);
      checks++; if (a != k + WDT) begin errors++; $display("FAIL wdt_expiry: got edge %0d expected %0d", a, k + WDT); end
      checks++; if (cause !== 2'b11) begin errors++; $display("FAIL wdt_cause: got %b expected 11", cause); end
   endtask
`endif

   initial begin
      test_reset();
      test_power_up();
      test_lock_glitch();
      test_button_bounce();
      test_simultaneous();
      test_async_reset();
`ifdef PULPEMU_RST_WDT_EN
      test_wdt();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
